numbers_parity_rx: RTL and testbench



---
 rtl/numbers_pkg.sv | 24 ++
 rtl/numbers_parity_rx_buf.sv | 61 ++++++
 rtl/numbers_parity_rx.sv | 127 ++++++++++++
 tb/tb_numbers_parity_rx.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/numbers_pkg.sv
// Shared types and helpers for the numbers parity receive path.
// No logic of its own: state encoding, output flag bundle, saturating counter step.
// Not applicable (no handshake here).
package numbers_pkg;

    localparam int CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY
    } rx_state_t;

    typedef struct packed {
        logic par_err;
        logic all_ones;
        logic any_one;
    } rx_flags_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : CNT_W'(v + 1'b1);
    endfunction

endpackage

// File: rtl/numbers_parity_rx_buf.sv
// One-entry holding register for completed frames, with drop counting.
// Latency: a loaded word is visible the cycle after in_vld.
// Backpressure: loads when empty or popped the same cycle; otherwise the new frame is dropped.
module numbers_parity_rx_buf
    import numbers_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_vld,
    input  logic [DATA_W-1:0] in_dat,
    input  rx_flags_t         in_flg,
    input  logic              out_rdy,
    output logic              out_vld,
    output logic [DATA_W-1:0] out_dat,
    output rx_flags_t         out_flg,
    output logic [CNT_W-1:0]  drop_cnt
);

    logic              vld_q, vld_d;
    logic [DATA_W-1:0] dat_q, dat_d;
    rx_flags_t         flg_q, flg_d;
    logic [CNT_W-1:0]  drop_q, drop_d;

    always_comb begin
        vld_d  = vld_q;
        dat_d  = dat_q;
        flg_d  = flg_q;
        drop_d = drop_q;
        if (in_vld && (!vld_q || out_rdy)) begin
            vld_d = 1'b1;
            dat_d = in_dat;
            flg_d = in_flg;
        end else if (in_vld) begin
            drop_d = sat_inc(drop_q);
        end else if (out_rdy) begin
            vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q  <= 1'b0;
            dat_q  <= '0;
            flg_q  <= '0;
            drop_q <= '0;
        end else begin
            vld_q  <= vld_d;
            dat_q  <= dat_d;
            flg_q  <= flg_d;
            drop_q <= drop_d;
        end
    end

    assign out_vld  = vld_q;
    assign out_dat  = dat_q;
    assign out_flg  = flg_q;
    assign drop_cnt = drop_q;

endmodule

// File: rtl/numbers_parity_rx.sv
// Serial LSB-first receiver of parity-protected words with AND/OR/XOR reduction flags.
// Latency: out_valid rises the cycle after the parity bit is sampled.
// Backpressure: none on the serial side; frames completing into a full, unpopped buffer are dropped.
module numbers_parity_rx
    import numbers_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter bit ODD_PARITY = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic              in_bit,
    input  logic              in_sof,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_par_err,
    output logic              out_all_ones,
    output logic              out_any_one,
    output logic [CNT_W-1:0]  drop_cnt,
    output logic [CNT_W-1:0]  abort_cnt
);

    localparam int IDX_W = $clog2(DATA_W);

    rx_state_t         state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [DATA_W-1:0] sh_q, sh_d;
    logic              acc_and_q, acc_and_d;
    logic              acc_or_q, acc_or_d;
    logic              acc_xor_q, acc_xor_d;
    logic [CNT_W-1:0]  abort_q, abort_d;
    logic              frame_vld;
    rx_flags_t         frame_flg;
    rx_flags_t         buf_flg;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        sh_d      = sh_q;
        acc_and_d = acc_and_q;
        acc_or_d  = acc_or_q;
        acc_xor_d = acc_xor_q;
        abort_d   = abort_q;
        frame_vld = 1'b0;
        frame_flg.par_err  = acc_xor_q ^ in_bit ^ ODD_PARITY;
        frame_flg.all_ones = acc_and_q;
        frame_flg.any_one  = acc_or_q;

        if (in_valid) begin
            if (in_sof) begin
                // A start-of-frame always wins, restarting any frame in flight.
                if (state_q != IDLE) begin
                    abort_d = sat_inc(abort_q);
                end
                state_d   = DATA;
                idx_d     = IDX_W'(1);
                sh_d      = {in_bit, sh_q[DATA_W-1:1]};
                acc_and_d = in_bit;
                acc_or_d  = in_bit;
                acc_xor_d = in_bit;
            end else begin
                unique case (state_q)
                    DATA: begin
                        sh_d      = {in_bit, sh_q[DATA_W-1:1]};
                        acc_and_d = acc_and_q & in_bit;
                        acc_or_d  = acc_or_q | in_bit;
                        acc_xor_d = acc_xor_q ^ in_bit;
                        idx_d     = IDX_W'(idx_q + 1'b1);
                        if (idx_q == IDX_W'(DATA_W - 1)) begin
                            state_d = PARITY;
                        end
                    end
                    PARITY: begin
                        frame_vld = 1'b1;
                        state_d   = IDLE;
                    end
                    default: begin
                        state_d = IDLE;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            sh_q      <= '0;
            acc_and_q <= 1'b0;
            acc_or_q  <= 1'b0;
            acc_xor_q <= 1'b0;
            abort_q   <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            sh_q      <= sh_d;
            acc_and_q <= acc_and_d;
            acc_or_q  <= acc_or_d;
            acc_xor_q <= acc_xor_d;
            abort_q   <= abort_d;
        end
    end

    numbers_parity_rx_buf #(
        .DATA_W (DATA_W)
    ) u_buf (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_vld   (frame_vld),
        .in_dat   (sh_q),
        .in_flg   (frame_flg),
        .out_rdy  (out_ready),
        .out_vld  (out_valid),
        .out_dat  (out_data),
        .out_flg  (buf_flg),
        .drop_cnt (drop_cnt)
    );

    assign out_par_err  = buf_flg.par_err;
    assign out_all_ones = buf_flg.all_ones;
    assign out_any_one  = buf_flg.any_one;
    assign abort_cnt    = abort_q;

endmodule

// File: tb/tb_numbers_parity_rx.sv
// Randomised bench for numbers_parity_rx: even- and odd-parity instances share one stimulus stream
// and are compared every cycle against a frame-level model built from bit queues.
module tb_numbers_parity_rx;

    localparam int DATA_W = 8;

    logic clk = 1'b0;
    logic rst_n;
    logic in_valid, in_bit, in_sof, out_ready;

    logic              e_vld, o_vld;
    logic [DATA_W-1:0] e_dat, o_dat;
    logic              e_perr, o_perr, e_all, o_all, e_any, o_any;
    logic [7:0]        e_drop, o_drop, e_abort, o_abort;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    bit                q_bits[$];
    logic              m_vld;
    logic [DATA_W-1:0] m_dat;
    logic              m_par;
    int                m_drop, m_abort;

    always #5 clk = ~clk;

    numbers_parity_rx #(.DATA_W(DATA_W), .ODD_PARITY(1'b0)) u_even (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_bit(in_bit), .in_sof(in_sof),
        .out_valid(e_vld), .out_ready(out_ready), .out_data(e_dat), .out_par_err(e_perr),
        .out_all_ones(e_all), .out_any_one(e_any), .drop_cnt(e_drop), .abort_cnt(e_abort)
    );

    numbers_parity_rx #(.DATA_W(DATA_W), .ODD_PARITY(1'b1)) u_odd (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_bit(in_bit), .in_sof(in_sof),
        .out_valid(o_vld), .out_ready(out_ready), .out_data(o_dat), .out_par_err(o_perr),
        .out_all_ones(o_all), .out_any_one(o_any), .drop_cnt(o_drop), .abort_cnt(o_abort)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        q_bits.delete();
        m_vld   = 1'b0;
        m_dat   = '0;
        m_par   = 1'b0;
        m_drop  = 0;
        m_abort = 0;
    endtask

    task automatic model_step(input bit v, input bit b, input bit sof, input bit rdy);
        bit                done = 0;
        logic [DATA_W-1:0] word = '0;
        bit                pbit = 0;
        if (v) begin
            if (sof) begin
                if (q_bits.size() > 0) m_abort = (m_abort < 255) ? m_abort + 1 : 255;
                q_bits.delete();
                q_bits.push_back(b);
            end else if (q_bits.size() > 0) begin
                q_bits.push_back(b);
                if (q_bits.size() == DATA_W + 1) begin
                    for (int i = 0; i < DATA_W; i++) word[i] = q_bits[i];
                    pbit = q_bits[DATA_W];
                    done = 1;
                    q_bits.delete();
                end
            end
        end
        if (done) begin
            if (!m_vld || rdy) begin
                m_vld = 1'b1;
                m_dat = word;
                m_par = pbit;
            end else begin
                m_drop = (m_drop < 255) ? m_drop + 1 : 255;
            end
        end else if (rdy) begin
            m_vld = 1'b0;
        end
    endtask

    task automatic compare_all();
        logic exp_perr_even;
        exp_perr_even = (^m_dat) ^ m_par;
        check_eq("vld_even", e_vld, m_vld);
        check_eq("vld_odd", o_vld, m_vld);
        if (m_vld) begin
            check_eq("dat_even", e_dat, m_dat);
            check_eq("dat_odd", o_dat, m_dat);
            check_eq("perr_even", e_perr, exp_perr_even);
            check_eq("perr_odd", o_perr, !exp_perr_even);
            check_eq("all_ones", {e_all, o_all}, {2{m_dat == {DATA_W{1'b1}}}});
            check_eq("any_one", {e_any, o_any}, {2{m_dat != '0}});
        end
        check_eq("drop_even", e_drop, m_drop);
        check_eq("drop_odd", o_drop, m_drop);
        check_eq("abort_even", e_abort, m_abort);
        check_eq("abort_odd", o_abort, m_abort);
    endtask

    task automatic step(input bit v, input bit b, input bit sof, input bit rdy);
        in_valid  = v;
        in_bit    = b;
        in_sof    = sof;
        out_ready = rdy;
        @(posedge clk);
        model_step(v, b, sof, rdy);
        #1;
        compare_all();
    endtask

    // rdy_mode: 0 = low, 1 = high, 2 = random per cycle
    task automatic send_bits(input logic [DATA_W:0] bits, input int nbits, input int max_gap,
                             input int rdy_mode);
        for (int i = 0; i < nbits; i++) begin
            int gap;
            gap = (max_gap > 0) ? $urandom_range(max_gap, 0) : 0;
            for (int g = 0; g < gap; g++)
                step(1'b0, 1'($urandom), 1'($urandom), (rdy_mode == 2) ? 1'($urandom) : 1'(rdy_mode));
            step(1'b1, bits[i], (i == 0), (rdy_mode == 2) ? 1'($urandom) : 1'(rdy_mode));
        end
    endtask

    task automatic send_frame(input logic [DATA_W-1:0] word, input bit pbit, input int max_gap,
                              input int rdy_mode);
        send_bits({pbit, word}, DATA_W + 1, max_gap, rdy_mode);
    endtask

    task automatic check_zero_outputs(input string tag);
        check_eq(tag, {e_vld, e_dat, e_perr, e_all, e_any, e_drop, e_abort}, '0);
        check_eq(tag, {o_vld, o_dat, o_perr, o_all, o_any, o_drop, o_abort}, '0);
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_bit = 1'b0;
        in_sof = 1'b0;
        out_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_zero_outputs("reset_state");
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, 1'b0, 1'b0, 1'b1);

        // 0xA5, correct even parity
        send_frame(8'hA5, 1'b0, 0, 1);
        check_eq("a5_vld", e_vld, 1);
        check_eq("a5_dat", e_dat, 8'hA5);
        check_eq("a5_flags", {e_perr, e_all, e_any}, 3'b001);

        // 0xFF with parity bit 1: wrong for even, right for odd
        send_frame(8'hFF, 1'b1, 0, 1);
        check_eq("ff_flags_even", {e_perr, e_all, e_any}, 3'b111);
        check_eq("ff_perr_odd", o_perr, 0);

        // Backpressure: second frame dropped, first held
        step(1'b0, 1'b0, 1'b0, 1'b1);
        send_frame(8'h01, 1'b1, 0, 0);
        send_frame(8'h02, 1'b1, 0, 0);
        check_eq("bp_dat", e_dat, 8'h01);
        check_eq("bp_drop", e_drop, 1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        check_eq("bp_pop_vld", e_vld, 0);

        // Abort at bit 4, then full 0x3C
        send_bits(9'h0F0, 4, 0, 1);
        send_frame(8'h3C, 1'b0, 0, 1);
        check_eq("abort_cnt", e_abort, 1);
        check_eq("abort_dat", e_dat, 8'h3C);

        // 0x5A gap-free then with random gaps
        send_frame(8'h5A, 1'b0, 0, 1);
        check_eq("gap0_res", {e_vld, e_dat, e_perr}, {1'b1, 8'h5A, 1'b0});
        step(1'b0, 1'b0, 1'b0, 1'b1);
        send_frame(8'h5A, 1'b0, 3, 1);
        check_eq("gap3_res", {e_vld, e_dat, e_perr}, {1'b1, 8'h5A, 1'b0});

        // Random traffic with aborts, gaps and random backpressure
        for (int f = 0; f < 80; f++) begin
            if ($urandom_range(7, 0) == 0)
                send_bits(9'($urandom), $urandom_range(DATA_W, 1), 2, 2);
            send_frame(8'($urandom), 1'($urandom), $urandom_range(2, 0), 2);
        end

        // Reset mid-DATA with a word held
        step(1'b0, 1'b0, 1'b0, 1'b1);
        send_frame(8'hC3, 1'b0, 0, 0);
        send_bits(9'h1FF, 3, 0, 0);
        rst_n = 1'b0;
        model_reset();
        #1;
        check_zero_outputs("reset_mid");
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        send_frame(8'h96, 1'b0, 1, 1);
        check_eq("post_reset", {e_vld, e_dat, e_perr, e_all, e_any}, {1'b1, 8'h96, 3'b001});

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
